nu_bank_mapper: RTL and testbench
=================================

Name: nu_bank_mapper

Overview:
- Parametrised successor to the 6509 bank adapter: a 65xx core runs in a 6509 system, with 6509-style bank registers mapped into the address space.
- Holds an execution bank register at REG_BASE and an indirect bank register at REG_BASE+1.
- Tracks indirect-indexed opcodes so the indirect bank is driven only on their data cycles.
- Widens the bank from BANK_WIDTH (compat) to EXT_WIDTH bits once a key-sequence unlock is written.
- Sits between the CPU address/data pins and the upper system address bus.

Parameters:
- BANK_WIDTH, 4: bank bits visible in compat mode; upper bits read and drive as 0.
- EXT_WIDTH, 8: bank register and address_bank width; must be >= BANK_WIDTH and <= 8.
- REG_BASE, 16'h0000: address of the execution bank register; must be even. Indirect register is at REG_BASE+1.
- KEY0 / KEY1 / KEY2, 8'h55 / 8'hAA / 8'h00: unlock key bytes.

Ports:
- phi2_6509  in  1  system clock; all state updates on the rising edge.
- _reset  in  1  synchronous, active-low reset.
- r_w  in  1  CPU read(1)/write(0).
- _rdy  in  1  1 = CPU advances this cycle.
- sync  in  1  opcode-fetch cycle indicator.
- address_6502  in  16  CPU address.
- data_in  in  8  CPU data bus, write path and opcode fetch.
- data_out  out  8  register readback data.
- data_oe  out  1  1 = drive data_out onto the CPU bus.
- address_bank  out  EXT_WIDTH  bank address to the system.
- sel_indirect  out  1  1 = indirect bank is selected this cycle.
- flag_full  out  1  1 = extended (full-width) mode.

Behaviour:
- Reset (_reset=0 at clock edge):
  - exec_bank = ind_bank = all-ones in the low BANK_WIDTH bits, 0 above (8'h0F for defaults).
  - flag_full=0, unlock FSM=IDLE, opcode pipeline cleared, sel_indirect=0.
  - address_bank = 4'hF zero-extended.
  - Reset mid-instruction aborts tracking; no stale indirect selection.
- Register write:
  - Condition: edge with r_w=0 and address_6502 = REG_BASE or REG_BASE+1.
  - Full 8-bit data_in is stored regardless of mode. _rdy is ignored for writes.
- Readback:
  - data_oe = r_w & address hit (combinational).
  - data_out = addressed register, masked to BANK_WIDTH bits when flag_full=0.
  - data_out = 0 when data_oe=0.
- address_bank (combinational): sel_indirect ? ind_bank : exec_bank, masked to BANK_WIDTH bits when flag_full=0.
- Opcode tracking:
  - T0 is an edge with sync=1, _rdy=1 and data_in in {8'h91, 8'hB1}.
  - T0 loads a one-hot cycle pipeline and records the class as Y-indexed.
  - The pipeline advances only on edges with _rdy=1; _rdy=0 freezes the pipeline and holds sel_indirect.
  - Any qualifying sync edge with a non-matching opcode clears the pipeline.
  - A matching opcode while the pipeline is active restarts it at T0.
- sel_indirect for the Y-indexed class:
  - 1 during T4.
  - 1 during T5 unless sync=1 (sync=1 at T5 means a no-page-cross LDA (zp),Y finished at T4).
  - 0 otherwise.
- Unlock FSM (advances only on writes to REG_BASE+1):
  - IDLE: data==KEY0 -> K1, else stay IDLE.
  - K1: data==KEY1 -> K2, else IDLE.
  - K2: data==KEY2 -> ARM, else IDLE.
  - ARM: flag_full <= data_in[0], -> IDLE.
  - A mismatching byte returns to IDLE and is not re-evaluated as KEY0.
  - Writes to REG_BASE, and all reads, leave the FSM unchanged.
  - Key writes also update ind_bank as normal writes.
- Simultaneous events:
  - A register write in the same cycle as T4/T5 still stores.
  - address_bank reflects the new value from the next cycle.

Optional Feature:
- Macro: NU_BANK_INDX_EN.
- Defined:
  - Opcodes 8'h81 (STA (zp,X)) and 8'hA1 (LDA (zp,X)) also start tracking, recorded as X-indexed class.
  - For this class sel_indirect=1 only during T5; sync is ignored.
- Undefined: 8'h81/8'hA1 are treated as non-matching opcodes.

Test Plan:
- Reset, read $0000 and $0001 -> data_oe=1, data_out=8'h0F each; address_bank=8'h0F.
- Write $0000=8'h03, $0001=8'hF2 -> compat readback 8'h03 / 8'h02. LDA (zp),Y page-cross (sync at T0 and T6) -> address_bank 3,3,3,3,2,2,3.
- Same LDA (zp),Y with no page cross (sync at T5) -> address_bank 2 at T4 only, 3 at T5.
- STA (zp),Y with _rdy=0 held 2 cycles at T2 -> sel_indirect asserted exactly on post-stall T4 and T5.
- Write $0001 sequence 55,AA,00,01 -> flag_full=1; readback $0001=8'h01, full 8-bit address_bank. Sequence 55,AA,00,00 -> flag_full=0. Sequence 55,12,AA,00,01 -> flag_full unchanged.
- With NU_BANK_INDX_EN: opcode 8'hA1 -> sel_indirect only at T5. Without the macro -> sel_indirect never asserts.

Source files
------------

// File: rtl/nu_bank_mapper_if.sv
// CPU-side bus bundle for nu_bank_mapper: 65xx pin inputs, plus the
// register readback, bank address and status outputs.
interface nu_bank_mapper_if #(
  parameter int unsigned EXT_WIDTH = 8
);
  logic                 r_w;
  logic                 _rdy;
  logic                 sync;
  logic [15:0]          address_6502;
  logic [7:0]           data_in;
  logic [7:0]           data_out;
  logic                 data_oe;
  logic [EXT_WIDTH-1:0] address_bank;
  logic                 sel_indirect;
  logic                 flag_full;

  modport master (
    output r_w, _rdy, sync, address_6502, data_in,
    input  data_out, data_oe, address_bank, sel_indirect, flag_full
  );

  modport slave (
    input  r_w, _rdy, sync, address_6502, data_in,
    output data_out, data_oe, address_bank, sel_indirect, flag_full
  );
endinterface

// File: rtl/nu_bank_mapper.sv
// 6509-style bank mapper: exec/indirect bank registers, (zp),Y tracking, key-sequence unlock.
// Optional NU_BANK_INDX_EN: also track (zp,X) opcodes 8'h81/8'hA1.
//
// unlock state | meaning
// ST_IDLE      | waiting for KEY0 on a write to REG_BASE+1
// ST_K1        | KEY0 seen, expecting KEY1
// ST_K2        | KEY1 seen, expecting KEY2
// ST_ARM       | next write to REG_BASE+1 loads flag_full from data bit 0
module nu_bank_mapper #(
  parameter int unsigned BANK_WIDTH = 4,
  parameter int unsigned EXT_WIDTH  = 8,
  parameter logic [15:0] REG_BASE   = 16'h0000,
  parameter logic [7:0]  KEY0       = 8'h55,
  parameter logic [7:0]  KEY1       = 8'hAA,
  parameter logic [7:0]  KEY2       = 8'h00
) (
  input logic               phi2_6509,
  input logic               _reset,
  nu_bank_mapper_if.slave   bus
);

  localparam logic [7:0]  COMPAT_MASK = 8'((1 << BANK_WIDTH) - 1);
  localparam logic [7:0]  FULL_MASK   = 8'((1 << EXT_WIDTH) - 1);
  localparam logic [15:0] REG_IND     = REG_BASE + 16'd1;

  typedef enum logic [1:0] {ST_IDLE, ST_K1, ST_K2, ST_ARM} unlock_e;

  logic [7:0] exec_bank_q, exec_bank_d;
  logic [7:0] ind_bank_q, ind_bank_d;
  logic       flag_full_q, flag_full_d;
  unlock_e    unlock_q, unlock_d;
  logic [4:0] pipe_q, pipe_d;   // one-hot T1..T5 of a tracked opcode
  logic       cls_x_q, cls_x_d;

  logic       hit_exec, hit_ind, wr_exec, wr_ind;
  logic       op_y, op_x;
  logic       sel_ind;
  logic [7:0] mask, rd_data, bank_sel;

  always_comb begin
    hit_exec = (bus.address_6502 == REG_BASE);
    hit_ind  = (bus.address_6502 == REG_IND);
    wr_exec  = ~bus.r_w & hit_exec;
    wr_ind   = ~bus.r_w & hit_ind;
    op_y     = (bus.data_in == 8'h91) | (bus.data_in == 8'hB1);
`ifdef NU_BANK_INDX_EN
    op_x     = (bus.data_in == 8'h81) | (bus.data_in == 8'hA1);
`else
    op_x     = 1'b0;
`endif
  end

  always_comb begin
    exec_bank_d = wr_exec ? bus.data_in : exec_bank_q;
    ind_bank_d  = wr_ind  ? bus.data_in : ind_bank_q;

    pipe_d  = pipe_q;
    cls_x_d = cls_x_q;
    if (bus._rdy) begin
      if (bus.sync) begin
        if (op_y | op_x) begin
          pipe_d  = 5'b00001;
          cls_x_d = op_x;
        end else begin
          pipe_d  = '0;
        end
      end else begin
        pipe_d = {pipe_q[3:0], 1'b0};
      end
    end

    unlock_d    = unlock_q;
    flag_full_d = flag_full_q;
    if (wr_ind) begin
      case (unlock_q)
        ST_IDLE: unlock_d = (bus.data_in == KEY0) ? ST_K1  : ST_IDLE;
        ST_K1:   unlock_d = (bus.data_in == KEY1) ? ST_K2  : ST_IDLE;
        ST_K2:   unlock_d = (bus.data_in == KEY2) ? ST_ARM : ST_IDLE;
        default: begin
          flag_full_d = bus.data_in[0];
          unlock_d    = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge phi2_6509) begin
    if (!_reset) begin
      exec_bank_q <= COMPAT_MASK;
      ind_bank_q  <= COMPAT_MASK;
      flag_full_q <= 1'b0;
      unlock_q    <= ST_IDLE;
      pipe_q      <= '0;
      cls_x_q     <= 1'b0;
    end else begin
      exec_bank_q <= exec_bank_d;
      ind_bank_q  <= ind_bank_d;
      flag_full_q <= flag_full_d;
      unlock_q    <= unlock_d;
      pipe_q      <= pipe_d;
      cls_x_q     <= cls_x_d;
    end
  end

  // sync at T5 of a (zp),Y op means it ended at T4 (no page cross)
  always_comb begin
    sel_ind  = cls_x_q ? pipe_q[4] : (pipe_q[3] | (pipe_q[4] & ~bus.sync));
    mask     = flag_full_q ? FULL_MASK : COMPAT_MASK;
    rd_data  = hit_ind ? ind_bank_q : exec_bank_q;
    bank_sel = (sel_ind ? ind_bank_q : exec_bank_q) & mask;
  end

  assign bus.data_oe      = bus.r_w & (hit_exec | hit_ind);
  assign bus.data_out     = bus.data_oe ? (rd_data & mask) : 8'h00;
  assign bus.address_bank = bank_sel[EXT_WIDTH-1:0];
  assign bus.sel_indirect = sel_ind;
  assign bus.flag_full    = flag_full_q;

endmodule

// File: tb/tb_nu_bank_mapper.sv
// Directed bench for nu_bank_mapper: readback, (zp),Y bank switching, stalls, unlock, reset.
module tb_nu_bank_mapper;

  logic clk = 1'b0;
  logic rst_b;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [7:0] xs_bank;
  logic       xs_sel;

  always #5 clk = ~clk;

  nu_bank_mapper_if #(.EXT_WIDTH(8)) bus ();

  nu_bank_mapper #(
    .BANK_WIDTH(4), .EXT_WIDTH(8), .REG_BASE(16'h0000),
    .KEY0(8'h55), .KEY1(8'hAA), .KEY2(8'h00)
  ) dut (
    .phi2_6509 (clk),
    ._reset    (rst_b),
    .bus       (bus.slave)
  );

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic rdy, input logic sy,
                       input logic [15:0] a, input logic [7:0] d);
    bus.r_w          = rw;
    bus._rdy         = rdy;
    bus.sync         = sy;
    bus.address_6502 = a;
    bus.data_in      = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    drive(1'b0, 1'b1, 1'b0, a, d);
    step();
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
    drive(1'b1, 1'b1, 1'b0, a, 8'h00);
    #2;
    chk({tag, ".oe"}, 8'(bus.data_oe), 8'h01);
    chk(tag, bus.data_out, exp);
    step();
  endtask

  // one CPU read cycle away from the registers; checks bank and select
  task automatic cyc(input string tag, input logic rdy, input logic sy, input logic [7:0] d,
                     input logic [7:0] exp_bank, input logic exp_sel);
    drive(1'b1, rdy, sy, 16'h0200, d);
    #2;
    chk({tag, ".bank"}, bus.address_bank, exp_bank);
    chk({tag, ".sel"}, 8'(bus.sel_indirect), 8'(exp_sel));
    step();
  endtask

  initial begin
`ifdef NU_BANK_INDX_EN
    xs_bank = 8'h01;
    xs_sel  = 1'b1;
`else
    xs_bank = 8'h07;
    xs_sel  = 1'b0;
`endif
    rst_b = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 16'h0200, 8'h00);
    step();
    step();
    rst_b = 1'b1;
    chk("rst_flag", 8'(bus.flag_full), 8'h00);
    chk("rst_sel", 8'(bus.sel_indirect), 8'h00);
    chk("rst_bank", bus.address_bank, 8'h0F);
    rd("rst_exec", 16'h0000, 8'h0F);
    rd("rst_ind", 16'h0001, 8'h0F);
    drive(1'b1, 1'b1, 1'b0, 16'h1234, 8'h00);
    #2;
    chk("miss_oe", 8'(bus.data_oe), 8'h00);
    chk("miss_data", bus.data_out, 8'h00);
    step();

    wr(16'h0000, 8'h03);
    wr(16'h0001, 8'hF2);
    rd("compat_exec", 16'h0000, 8'h03);
    rd("compat_ind", 16'h0001, 8'h02);

    // LDA (zp),Y with page cross: sync at T0 and T6
    cyc("pc_t0", 1'b1, 1'b1, 8'hB1, 8'h03, 1'b0);
    cyc("pc_t1", 1'b1, 1'b0, 8'h00, 8'h03, 1'b0);
    cyc("pc_t2", 1'b1, 1'b0, 8'h00, 8'h03, 1'b0);
    cyc("pc_t3", 1'b1, 1'b0, 8'h00, 8'h03, 1'b0);
    cyc("pc_t4", 1'b1, 1'b0, 8'h00, 8'h02, 1'b1);
    cyc("pc_t5", 1'b1, 1'b0, 8'h00, 8'h02, 1'b1);
    cyc("pc_t6", 1'b1, 1'b1, 8'hEA, 8'h03, 1'b0);
    cyc("pc_after", 1'b1, 1'b0, 8'h00, 8'h03, 1'b0);

    // LDA (zp),Y without page cross: sync at T5
    cyc("npc_t0", 1'b1, 1'b1, 8'hB1, 8'h03, 1'b0);
    cyc("npc_t1", 1'b1, 1'b0, 8'h00, 8'h03, 1'b0);
    cyc("npc_t2", 1'b1, 1'b0, 8'h00, 8'h03, 1'b0);
    cyc("npc_t3", 1'b1, 1'b0, 8'h00, 8'h03, 1'b0);
    cyc("npc_t4", 1'b1, 1'b0, 8'h00, 8'h02, 1'b1);
    cyc("npc_t5", 1'b1, 1'b1, 8'hEA, 8'h03, 1'b0);
    cyc("npc_after", 1'b1, 1'b0, 8'h00, 8'h03, 1'b0);

    // STA (zp),Y stalled two cycles at T2
    cyc("sta_t0", 1'b1, 1'b1, 8'h91, 8'h03, 1'b0);
    cyc("sta_t1", 1'b1, 1'b0, 8'h00, 8'h03, 1'b0);
    cyc("sta_t2s0", 1'b0, 1'b0, 8'h00, 8'h03, 1'b0);
    cyc("sta_t2s1", 1'b0, 1'b0, 8'h00, 8'h03, 1'b0);
    cyc("sta_t2", 1'b1, 1'b0, 8'h00, 8'h03, 1'b0);
    cyc("sta_t3", 1'b1, 1'b0, 8'h00, 8'h03, 1'b0);
    cyc("sta_t4", 1'b1, 1'b0, 8'h00, 8'h02, 1'b1);
    cyc("sta_t5", 1'b1, 1'b0, 8'h00, 8'h02, 1'b1);
    cyc("sta_t6", 1'b1, 1'b1, 8'hEA, 8'h03, 1'b0);

    // register write landing on T4 takes effect from T5
    cyc("sim_t0", 1'b1, 1'b1, 8'hB1, 8'h03, 1'b0);
    cyc("sim_t1", 1'b1, 1'b0, 8'h00, 8'h03, 1'b0);
    cyc("sim_t2", 1'b1, 1'b0, 8'h00, 8'h03, 1'b0);
    cyc("sim_t3", 1'b1, 1'b0, 8'h00, 8'h03, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 16'h0001, 8'h04);
    #2;
    chk("sim_t4.bank", bus.address_bank, 8'h02);
    chk("sim_t4.sel", 8'(bus.sel_indirect), 8'h01);
    step();
    cyc("sim_t5", 1'b1, 1'b0, 8'h00, 8'h04, 1'b1);
    cyc("sim_t6", 1'b1, 1'b1, 8'hEA, 8'h03, 1'b0);

    // matching opcode mid-instruction restarts at T0
    cyc("rs_t0", 1'b1, 1'b1, 8'hB1, 8'h03, 1'b0);
    cyc("rs_t1", 1'b1, 1'b0, 8'h00, 8'h03, 1'b0);
    cyc("rs_t0b", 1'b1, 1'b1, 8'hB1, 8'h03, 1'b0);
    cyc("rs_t1b", 1'b1, 1'b0, 8'h00, 8'h03, 1'b0);
    cyc("rs_t2b", 1'b1, 1'b0, 8'h00, 8'h03, 1'b0);
    cyc("rs_t3b", 1'b1, 1'b0, 8'h00, 8'h03, 1'b0);
    cyc("rs_t4b", 1'b1, 1'b0, 8'h00, 8'h04, 1'b1);
    cyc("rs_t5b", 1'b1, 1'b0, 8'h00, 8'h04, 1'b1);
    cyc("rs_t6b", 1'b1, 1'b1, 8'hEA, 8'h03, 1'b0);

    // unlock sequences
    wr(16'h0001, 8'h55); wr(16'h0001, 8'hAA); wr(16'h0001, 8'h00); wr(16'h0001, 8'h01);
    chk("unl_flag", 8'(bus.flag_full), 8'h01);
    rd("unl_ind", 16'h0001, 8'h01);
    chk("unl_bank", bus.address_bank, 8'h03);
    wr(16'h0000, 8'hA5);
    chk("full_bank", bus.address_bank, 8'hA5);
    rd("full_exec", 16'h0000, 8'hA5);

    wr(16'h0001, 8'h55); wr(16'h0001, 8'hAA); wr(16'h0001, 8'h00); wr(16'h0001, 8'h00);
    chk("lock_flag", 8'(bus.flag_full), 8'h00);
    chk("lock_bank", bus.address_bank, 8'h05);
    rd("lock_ind", 16'h0001, 8'h00);

    wr(16'h0001, 8'h55); wr(16'h0001, 8'h12); wr(16'h0001, 8'hAA);
    wr(16'h0001, 8'h00); wr(16'h0001, 8'h01);
    chk("badkey_flag", 8'(bus.flag_full), 8'h00);
    rd("badkey_ind", 16'h0001, 8'h01);

    wr(16'h0001, 8'h55); wr(16'h0000, 8'h07); wr(16'h0001, 8'hAA);
    wr(16'h0001, 8'h00); wr(16'h0001, 8'h01);
    chk("mixwr_flag", 8'(bus.flag_full), 8'h01);
    chk("mixwr_bank", bus.address_bank, 8'h07);

    // LDA (zp,X): tracked only with the indexed-X option
    cyc("x_t0", 1'b1, 1'b1, 8'hA1, 8'h07, 1'b0);
    cyc("x_t1", 1'b1, 1'b0, 8'h00, 8'h07, 1'b0);
    cyc("x_t2", 1'b1, 1'b0, 8'h00, 8'h07, 1'b0);
    cyc("x_t3", 1'b1, 1'b0, 8'h00, 8'h07, 1'b0);
    cyc("x_t4", 1'b1, 1'b0, 8'h00, 8'h07, 1'b0);
    cyc("x_t5", 1'b1, 1'b0, 8'h00, xs_bank, xs_sel);
    cyc("x_t6", 1'b1, 1'b1, 8'hEA, 8'h07, 1'b0);

    // reset during T4 drops the indirect selection
    cyc("mr_t0", 1'b1, 1'b1, 8'hB1, 8'h07, 1'b0);
    cyc("mr_t1", 1'b1, 1'b0, 8'h00, 8'h07, 1'b0);
    cyc("mr_t2", 1'b1, 1'b0, 8'h00, 8'h07, 1'b0);
    cyc("mr_t3", 1'b1, 1'b0, 8'h00, 8'h07, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 16'h0200, 8'h00);
    #2;
    chk("mr_t4.sel", 8'(bus.sel_indirect), 8'h01);
    chk("mr_t4.bank", bus.address_bank, 8'h01);
    rst_b = 1'b0;
    step();
    rst_b = 1'b1;
    chk("mr_flag", 8'(bus.flag_full), 8'h00);
    cyc("mr_p0", 1'b1, 1'b0, 8'h00, 8'h0F, 1'b0);
    cyc("mr_p1", 1'b1, 1'b0, 8'h00, 8'h0F, 1'b0);
    cyc("mr_p2", 1'b1, 1'b0, 8'h00, 8'h0F, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
